// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the word-oriented UART transmitter: FSM encoding,
// line levels and default sizing.
package uart_word_tx_pkg;

  // Serializer states
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // UART line levels
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Defaults: 50 MHz system clock, 115200 baud, 16-bit words as 8-bit frames
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_WORD_SIZE    = 16;
  localparam int DEFAULT_DATA_LENGTH  = 8;
  localparam int BYTES_PER_WORD       = DEFAULT_WORD_SIZE / DEFAULT_DATA_LENGTH;

  // Number of UART frames needed to carry one word
  function automatic int bytes_per_word(input int word_size, input int data_length);
    return word_size / data_length;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word handshake between a result producer and the UART word transmitter.
interface uart_word_tx_if
  import uart_word_tx_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
  logic [WORD_SIZE-1:0] i_word;
  logic                 i_word_valid;
  logic                 o_word_ready;

  // Producer side
  modport master (output i_word, output i_word_valid, input o_word_ready);
  // Transmitter side
  modport slave  (input i_word, input i_word_valid, output o_word_ready);
endinterface

// File: rtl/uart_word_tx_sync_word_fifo.sv
// Single-clock word FIFO with registered full flag and occupancy count.
// Read data is the word at the read pointer, so a pop consumes it on the same
// edge the consumer captures it.
module sync_word_fifo
  import uart_word_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_SIZE,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic             full_reg;
  logic             wr_en;
  logic             rd_en;

  // A push while full is dropped even if a pop frees a slot on the same edge
  assign wr_en = i_push && !full_reg;
  assign rd_en = i_pop && (level_reg != '0);

  // Occupancy: simultaneous push and pop leave the level unchanged
  always_comb begin
    level_next = level_reg;
    if (wr_en && !rd_en) begin
      level_next = level_reg + LVL_W'(1);
    end else if (rd_en && !wr_en) begin
      level_next = level_reg - LVL_W'(1);
    end
  end

  // Storage array; contents need no reset since the pointers gate every read
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  // Pointers, level and full flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
      full_reg  <= (level_next == LVL_W'(DEPTH));
    end
  end

  assign o_data  = mem[rd_ptr_reg];
  assign o_full  = full_reg;
  assign o_empty = (level_reg == '0);
  assign o_level = level_reg;

endmodule

// File: rtl/uart_word_tx.sv
// Word-oriented UART transmitter: buffers words in a FIFO and sends each one
// as a run of 8N1 frames, most-significant byte first, LSB-first within a byte.
// Frames of one word and consecutive words follow each other with no idle gap.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int DATA_LENGTH  = DEFAULT_DATA_LENGTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  uart_word_tx_if.slave               word_if,
  output logic                        o_TX_bit,
  output logic                        o_busy,
  output logic                        o_TX_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
  localparam int BPW    = bytes_per_word(WORD_SIZE, DATA_LENGTH);
  localparam int BYTE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int BIT_W  = $clog2(DATA_LENGTH);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);

  logic [WORD_SIZE-1:0]        fifo_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  tx_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      baud_reg, baud_next;
  logic [BIT_W-1:0]      bit_idx_reg, bit_idx_next;
  logic [BYTE_W-1:0]     byte_idx_reg, byte_idx_next;
  logic [WORD_SIZE-1:0]  word_reg, word_next;
  logic                  tx_reg, tx_next;
  logic                  done_reg, done_next;
  logic                  baud_wrap;
  logic [DATA_LENGTH-1:0] word_bytes [BPW];
  logic [DATA_LENGTH-1:0] cur_byte;

  sync_word_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (word_if.i_word_valid),
    .i_data  (word_if.i_word),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  // Byte lanes of the held word; lane 0 is the most-significant byte
  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    assign word_bytes[gi] = word_reg[WORD_SIZE-1-gi*DATA_LENGTH -: DATA_LENGTH];
  end

  assign cur_byte  = word_bytes[byte_idx_reg];
  assign baud_wrap = (baud_reg == CNT_W'(CLKS_PER_BIT - 1));

  // Next-state logic: baud counter, bit/byte sequencing and line level
  always_comb begin
    state_next    = state_reg;
    baud_next     = '0;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    word_next     = word_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    fifo_pop      = 1'b0;

    if (state_reg != IDLE && !baud_wrap) begin
      baud_next = baud_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        tx_next = IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          word_next     = fifo_data;
          byte_idx_next = '0;
          state_next    = START;
          tx_next       = START_BIT;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_idx_reg == BIT_W'(DATA_LENGTH - 1)) begin
            state_next = STOP;
            tx_next    = STOP_BIT;
          end else begin
            bit_idx_next = bit_idx_reg + BIT_W'(1);
            tx_next      = cur_byte[bit_idx_next];
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (byte_idx_reg != BYTE_W'(BPW - 1)) begin
            byte_idx_next = byte_idx_reg + BYTE_W'(1);
            state_next    = START;
            tx_next       = START_BIT;
          end else begin
            done_next = 1'b1;
            if (!fifo_empty) begin
              fifo_pop      = 1'b1;
              word_next     = fifo_data;
              byte_idx_next = '0;
              state_next    = START;
              tx_next       = START_BIT;
            end else begin
              state_next = IDLE;
              tx_next    = IDLE_LEVEL;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = IDLE_LEVEL;
      end
    endcase
  end

  // Serializer state; reset drives the line idle at once, even mid-frame
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
      tx_reg       <= IDLE_LEVEL;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      word_reg     <= word_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
    end
  end

  assign word_if.o_word_ready = !fifo_full;
  assign o_TX_bit             = tx_reg;
  assign o_TX_done            = done_reg;
  assign o_busy               = (state_reg != IDLE) || !fifo_empty;
  assign o_fifo_level         = fifo_level;

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: words are queued as they are accepted,
// a line decoder rebuilds words from the serial output, and each scenario
// compares decoded words, frame timing and status outputs.
module tb_uart_word_tx;
  localparam int WS       = 16;
  localparam int DL       = 8;
  localparam int CPB      = 4;
  localparam int DEPTH    = 16;
  localparam int FRAME    = (DL + 2) * CPB;
  localparam int WORD_CYC = FRAME * (WS / DL);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic busy;
  logic done;
  logic [$clog2(DEPTH):0] level;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int frame_err = 0;
  logic [WS-1:0] exp_q[$];
  logic [WS-1:0] rx_q[$];
  int frame_q[$];
  int done_q[$];

  uart_word_tx_if #(.WORD_SIZE(WS)) wif ();

  uart_word_tx #(
    .WORD_SIZE    (WS),
    .DATA_LENGTH  (DL),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .word_if      (wif),
    .o_TX_bit     (tx),
    .o_busy       (busy),
    .o_TX_done    (done),
    .o_fifo_level (level)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  // Line decoder: samples mid-bit on the falling edge, rebuilds MSB-first words
  initial begin : line_monitor
    bit active;
    int cnt;
    int nb;
    logic [DL-1:0] sh;
    logic [WS-1:0] acc;
    active = 1'b0; cnt = 0; nb = 0; sh = '0; acc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        nb = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt = 0;
          frame_q.push_back(cyc);
        end
      end else begin
        cnt++;
        if (cnt == CPB / 2 && tx !== 1'b0) frame_err++;
        if (cnt >= CPB && cnt < CPB * (DL + 1) && (cnt % CPB) == CPB / 2)
          sh[cnt / CPB - 1] = tx;
        if (cnt == CPB * (DL + 1) + CPB / 2) begin
          if (tx !== 1'b1) frame_err++;
          acc = {acc[WS-DL-1:0], sh};
          nb++;
          if (nb == WS / DL) begin
            rx_q.push_back(acc);
            $display("[%0d] rx word 0x%04h", cyc, acc);
            nb = 0;
          end
        end
        if (cnt == FRAME - 1) active = 1'b0;
      end
      if (rst_n && done === 1'b1) done_q.push_back(cyc);
    end
  end

  task automatic clear_queues();
    exp_q.delete();
    rx_q.delete();
    frame_q.delete();
    done_q.delete();
    frame_err = 0;
  endtask

  // Present a word for one edge; it is expected on the line only if accepted
  task automatic drive_word(input logic [WS-1:0] w, output bit accepted, output int edge_cyc);
    @(negedge clk);
    wif.i_word       = w;
    wif.i_word_valid = 1'b1;
    accepted = (wif.o_word_ready === 1'b1);
    @(posedge clk);
    #1;
    edge_cyc = cyc;
    if (accepted) exp_q.push_back(w);
  endtask

  task automatic drive_idle();
    @(negedge clk);
    wif.i_word_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
    checks++; if (wif.o_word_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", wif.o_word_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (level !== 0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL idle_after_reset_tx: got %b want 1", tx); else passed++;
  endtask

  task automatic test_single_word();
    bit a;
    int k, bad, f, p;
    logic [DL-1:0] b;
    logic e;
    logic [WS-1:0] w, got, want;
    w = 16'hA55A;
    clear_queues();
    drive_word(w, a, k);
    drive_idle();
    bad = 0;
    for (int i = 0; i < WORD_CYC; i++) begin
      @(negedge clk);
      f = i / FRAME;
      p = (i % FRAME) / CPB;
      b = DL'(w >> (WS - DL * (f + 1)));
      if (p == 0) e = 1'b0;
      else if (p == DL + 1) e = 1'b1;
      else e = b[p-1];
      if (i == 0) begin
        checks++; if (tx !== 1'b0) $display("FAIL single_latency: got %b want 0 at edge k+1", tx); else passed++;
      end
      if (tx !== e) bad++;
    end
    checks++; if (bad != 0) $display("FAIL single_waveform: got %0d wrong cycles want 0", bad); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b1) $display("FAIL single_done_pulse: got %b want 1", done); else passed++;
    checks++; if (tx !== 1'b1) $display("FAIL single_idle_line: got %b want 1", tx); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL single_done_width: got %b want 0", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else passed++;
    wait_rx(1, 10);
    checks++;
    if (done_q.size() != 1 || frame_q.size() == 0)
      $display("FAIL single_done_count: got %0d want 1", done_q.size());
    else if (done_q[0] - frame_q[0] != WORD_CYC)
      $display("FAIL single_done_time: got %0d want %0d", done_q[0] - frame_q[0], WORD_CYC);
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) $display("FAIL single_word: got none want 0x%04h", want);
      else begin
        got = rx_q.pop_front();
        if (got !== want) $display("FAIL single_word: got 0x%04h want 0x%04h", got, want); else passed++;
      end
    end
    checks++; if (frame_err != 0) $display("FAIL single_framing: got %0d errors want 0", frame_err); else passed++;
  endtask

  task automatic test_back_to_back();
    bit a;
    int k, k2, bad;
    logic [WS-1:0] got, want;
    clear_queues();
    drive_word(16'h0001, a, k);
    drive_word(16'h8000, a, k2);
    drive_word(16'hFFFF, a, k2);
    drive_idle();
    wait_rx(3, 3 * WORD_CYC + 40);
    repeat (4) @(negedge clk);
    checks++; if (frame_q.size() != 6) $display("FAIL b2b_frames: got %0d want 6", frame_q.size()); else passed++;
    bad = 0;
    for (int i = 1; i < frame_q.size(); i++) if (frame_q[i] - frame_q[i-1] != FRAME) bad++;
    checks++; if (bad != 0) $display("FAIL b2b_gap: got %0d gapped frames want 0", bad); else passed++;
    checks++;
    if (frame_q.size() == 0) $display("FAIL b2b_first_start: got none want %0d", k + 1);
    else if (frame_q[0] != k + 1) $display("FAIL b2b_first_start: got %0d want %0d", frame_q[0], k + 1);
    else passed++;
    bad = 0;
    for (int i = 1; i < done_q.size(); i++) if (done_q[i] - done_q[i-1] != WORD_CYC) bad++;
    checks++;
    if (done_q.size() != 3 || bad != 0)
      $display("FAIL b2b_done: got %0d pulses %0d bad spacings want 3 pulses 0 bad", done_q.size(), bad);
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) $display("FAIL b2b_word: got none want 0x%04h", want);
      else begin
        got = rx_q.pop_front();
        if (got !== want) $display("FAIL b2b_word: got 0x%04h want 0x%04h", got, want); else passed++;
      end
    end
    checks++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_fifo_full();
    bit a, saw_block;
    int idx, iter, ec, n_before, lvl_block, acc18;
    logic [WS-1:0] got, want;
    clear_queues();
    idx = 0; iter = 0; saw_block = 1'b0; n_before = -1; lvl_block = -1; acc18 = -1;
    while (idx < 18 && iter < 3000) begin
      drive_word(WS'(16'h1000 + idx * 16'h0103), a, ec);
      if (a) begin
        idx++;
        if (idx == 18) acc18 = ec;
      end else if (!saw_block) begin
        saw_block = 1'b1;
        n_before  = idx;
        lvl_block = int'(level);
      end
      iter++;
    end
    drive_idle();
    checks++; if (n_before != 17) $display("FAIL full_accepted_before_block: got %0d want 17", n_before); else passed++;
    checks++; if (lvl_block != DEPTH) $display("FAIL full_level: got %0d want %0d", lvl_block, DEPTH); else passed++;
    checks++; if (idx != 18) $display("FAIL full_word18_accepted: got %0d words want 18", idx); else passed++;
    wait_rx(18, 18 * WORD_CYC + 100);
    checks++;
    if (done_q.size() == 0) $display("FAIL full_word18_time: got no done pulse want one");
    else if (acc18 != done_q[0] + 1) $display("FAIL full_word18_time: got edge %0d want %0d", acc18, done_q[0] + 1);
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) $display("FAIL full_word: got none want 0x%04h", want);
      else begin
        got = rx_q.pop_front();
        if (got !== want) $display("FAIL full_word: got 0x%04h want 0x%04h", got, want); else passed++;
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_push_pop_level5();
    bit a;
    int e1, ec, p_edge, t;
    logic [WS-1:0] got, want;
    clear_queues();
    drive_word(16'h2000, a, e1);
    for (int i = 1; i < 6; i++) drive_word(WS'(16'h2000 + i * 16'h0405), a, ec);
    drive_idle();
    p_edge = e1 + 1 + WORD_CYC;
    t = 0;
    while (cyc < p_edge - 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++; if (level !== 5) $display("FAIL pp_level_before: got %0d want 5", level); else passed++;
    drive_word(16'h7777, a, ec);
    checks++; if (ec != p_edge || !a) $display("FAIL pp_push_edge: got edge %0d accepted %0b want edge %0d accepted 1", ec, a, p_edge); else passed++;
    checks++; if (done !== 1'b1) $display("FAIL pp_pop_same_edge: got done %b want 1", done); else passed++;
    checks++; if (level !== 5) $display("FAIL pp_level_after: got %0d want 5", level); else passed++;
    drive_idle();
    wait_rx(7, 7 * WORD_CYC + 50);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) $display("FAIL pp_word: got none want 0x%04h", want);
      else begin
        got = rx_q.pop_front();
        if (got !== want) $display("FAIL pp_word: got 0x%04h want 0x%04h", got, want); else passed++;
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bit a;
    int k, k2, t, lows, dones;
    logic [WS-1:0] got, want;
    clear_queues();
    drive_word(16'hC35A, a, k);
    drive_word(16'h7E81, a, k2);
    drive_idle();
    t = 0;
    while (cyc < k + 1 + 17 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++; if (tx !== 1'b0) $display("FAIL rst_mid_bit3: got %b want 0", tx); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL rst_tx_immediate: got %b want 1", tx); else passed++;
    checks++; if (level !== 0) $display("FAIL rst_level: got %0d want 0", level); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    lows = 0; dones = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (done === 1'b1) dones++;
    end
    checks++; if (lows != 0) $display("FAIL rst_line_idle: got %0d low cycles want 0", lows); else passed++;
    checks++; if (dones != 0) $display("FAIL rst_no_done: got %0d pulses want 0", dones); else passed++;
    checks++; if (rx_q.size() != 0) $display("FAIL rst_no_word: got %0d words want 0", rx_q.size()); else passed++;
    clear_queues();
    drive_word(16'h5AA5, a, k);
    drive_idle();
    wait_rx(1, WORD_CYC + 20);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) $display("FAIL rst_resume_word: got none want 0x%04h", want);
      else begin
        got = rx_q.pop_front();
        if (got !== want) $display("FAIL rst_resume_word: got 0x%04h want 0x%04h", got, want); else passed++;
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_drop_when_full();
    bit a;
    int ec, n_acc;
    logic [WS-1:0] got, want;
    clear_queues();
    n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      drive_word(WS'(16'h3000 + i * 16'h0111), a, ec);
      if (a) n_acc++;
    end
    checks++; if (n_acc != 17) $display("FAIL drop_fill: got %0d accepted want 17", n_acc); else passed++;
    drive_word(16'h1234, a, ec);
    checks++; if (a) $display("FAIL drop_ready: got ready 1 want 0"); else passed++;
    checks++; if (level !== DEPTH) $display("FAIL drop_level: got %0d want %0d", level, DEPTH); else passed++;
    drive_idle();
    wait_rx(17, 17 * WORD_CYC + 100);
    repeat (WORD_CYC + 20) @(negedge clk);
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) $display("FAIL drop_word: got none want 0x%04h", want);
      else begin
        got = rx_q.pop_front();
        if (got !== want) $display("FAIL drop_word: got 0x%04h want 0x%04h", got, want); else passed++;
      end
    end
    checks++; if (rx_q.size() != 0) $display("FAIL drop_extra_words: got %0d want 0", rx_q.size()); else passed++;
    checks++; if (busy !== 1'b0 || level !== 0) $display("FAIL drop_drained: got busy %b level %0d want 0 0", busy, level); else passed++;
  endtask

  initial begin
    wif.i_word       = '0;
    wif.i_word_valid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fifo_full();
    test_push_pop_level5();
    test_reset_mid_frame();
    test_drop_when_full();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
